rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, ROM address width.
REQ-002 Parameter DATA_W, default 16, ROM data width.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req0 / req1  input  1 each  read request from requester 0 / 1; held high with stable address until its valid pulse.
REQ-006 Port addr0 / addr1  input  ADDR_W each  read address of requester 0 / 1.
REQ-007 Port rdata0 / rdata1  output  DATA_W each  registered read data returned to requester 0 / 1.
REQ-008 Port valid0 / valid1  output  1 each  one-cycle pulse; rdataN holds the read data while validN is high.
REQ-009 Port rom_en  output  1  enable to the shared synchronous single-port ROM.
REQ-010 Port rom_addr  output  ADDR_W  address to the shared ROM.
REQ-011 Port rom_data  input  DATA_W  ROM output; valid on the edge after the edge at which rom_en/rom_addr were sampled.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states IDLE, ISSUE, RESP; all outputs registered.
REQ-014 IDLE: at a rising edge with an eligible request -> ISSUE; rom_en<=1, rom_addr<=addr of winner, winner id latched.
REQ-015 ISSUE: next edge -> RESP; rom_en<=0; ROM captures data at this edge.
REQ-016 RESP: next edge -> IDLE; rdataN<=rom_data and validN<=1 for the latched winner only; validN deasserts at the following edge.
REQ-017 Latency: request sampled at edge E0 -> validN high during the cycle after edge E2; one transaction per 3 cycles max.
REQ-018 Eligibility: requester N is not eligible at an edge where validN is currently high (its req is treated as already retired).
REQ-019 Arbitration round-robin: single requester eligible -> it wins; both eligible -> the one not served last wins.
REQ-020 Last-served pointer updates only on entry to ISSUE; after reset it indicates requester 1, so requester 0 wins the first tie.
REQ-021 Requests arriving during ISSUE/RESP are not sampled; they wait (no loss) until IDLE.
REQ-022 addrN changes while reqN high are a protocol violation; the address latched at E0 is used.
REQ-023 rdata0/rdata1 hold their last value when not being written.
REQ-024 valid0 and valid1 are never high in the same cycle.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE, rom_en 0, rom_addr 0, rdata0/1 0, valid0/1 0, busy 0, pointer = requester 1.
REQ-026 Reset during ISSUE or RESP discards the transaction; no valid pulse is produced for it after reset release.
REQ-027 First request is sampled at the first rising edge with rst_n high.

Structure
REQ-028 Package rom_arb_pkg holds the state encoding (IDLE, ISSUE, RESP) and default ADDR_W/DATA_W constants.
REQ-029 Sub-module rr_arb2 (two-input round-robin grant logic from req vector and last-served pointer) is instantiated once; the FSM and data registers stay in rom_arbiter.

Verification (bench ROM model: data = 16'hA000 | addr, one-cycle registered read)
REQ-030 Single read: req0=1, addr0=4'h3 -> rom_en one cycle with rom_addr=3; valid0 pulse three edges later with rdata0=16'hA003; valid1 stays 0.
REQ-031 Tie after reset: req0=1 addr0=4'h1, req1=1 addr1=4'h7 same cycle -> valid0 rdata0=16'hA001 first, then valid1 rdata1=16'hA007 three cycles later.
REQ-032 Fairness: both requesters held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; no back-to-back grant to one side.
REQ-033 Late request: req1 raised during ISSUE of a requester-0 read -> request-0 completes undisturbed, requester 1 is served next.
REQ-034 Reset mid-operation: rst_n low during RESP -> all outputs 0 immediately; no valid pulse after release; next req0 addr0=4'hF returns 16'hA00F.
REQ-035 Idle hold: no requests for 10 cycles -> rom_en, valid0, valid1, busy stay 0; rdata0/1 unchanged.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-requester ROM arbiter: FSM state encoding
// and default geometry of the shared ROM.
package rom_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic. Purely combinational: given the
// eligible request vector and the id of the requester served last, pick a
// winner. On a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_id,
  output logic       grant_any,
  output logic       grant_id
);

  // Select the winner from the eligible requests and the last-served pointer
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    case (req)
      2'b01: begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end
      2'b10: begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
      2'b11: begin
        grant_any = 1'b1;
        grant_id  = ~last_id;
      end
      default: begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous single-port ROM between two requesters. Each read
// takes three cycles (IDLE -> ISSUE -> RESP); the returned word is held in a
// per-requester data register and flagged with a one-cycle valid pulse.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              valid0,
  output logic              valid1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  arb_state_e        state_r;
  logic              winner_r;
  logic              last_r;
  logic              rom_en_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
  logic              valid0_r;
  logic              valid1_r;
  logic              busy_r;

  logic [1:0]        elig_s;
  logic              grant_any_s;
  logic              grant_id_s;

  // A requester whose valid pulse is showing has just been served; its
  // still-high req belongs to the finished read and must not re-win.
  assign elig_s = {req1 & ~valid1_r, req0 & ~valid0_r};

  rr_arb2 u_rr_arb2 (
    .req       (elig_s),
    .last_id   (last_r),
    .grant_any (grant_any_s),
    .grant_id  (grant_id_s)
  );

  // Read-sequencing FSM with all outputs and the data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      winner_r   <= 1'b0;
      last_r     <= 1'b1;
      rom_en_r   <= 1'b0;
      rom_addr_r <= {ADDR_W{1'b0}};
      rdata0_r   <= {DATA_W{1'b0}};
      rdata1_r   <= {DATA_W{1'b0}};
      valid0_r   <= 1'b0;
      valid1_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            state_r    <= ST_ISSUE;
            busy_r     <= 1'b1;
            rom_en_r   <= 1'b1;
            rom_addr_r <= grant_id_s ? addr1 : addr0;
            winner_r   <= grant_id_s;
            last_r     <= grant_id_s;
          end else begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            rom_en_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // The ROM samples rom_en/rom_addr at this edge
          state_r  <= ST_RESP;
          busy_r   <= 1'b1;
          rom_en_r <= 1'b0;
        end
        ST_RESP: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          rom_en_r <= 1'b0;
          if (winner_r) begin
            rdata1_r <= rom_data;
            valid1_r <= 1'b1;
          end else begin
            rdata0_r <= rom_data;
            valid0_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          rom_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign rdata0   = rdata0_r;
  assign rdata1   = rdata1_r;
  assign valid0   = valid0_r;
  assign valid1   = valid1_r;
  assign rom_en   = rom_en_r;
  assign rom_addr = rom_addr_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter. A transaction-level schedule model
// predicts, edge by edge, when each read is granted, when its data returns
// and what every output must show in each cycle.
module tb_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [3:0]  addr0, addr1;
  logic [15:0] rdata0, rdata1;
  logic        valid0, valid1;
  logic        rom_en;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference schedule model
  int          k;
  bit          txn;
  int          g_edge;
  bit          g_id;
  logic [3:0]  g_addr;
  int          v_edge [2];
  bit          last_srv;
  logic [15:0] exp_rd [2];

  bit          hold0, hold1;
  int          obs_id [$];
  logic [15:0] obs_data [$];

  rom_arbiter #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .valid0   (valid0),
    .valid1   (valid1),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: data = A000 | addr, one-cycle registered read
  always @(posedge clk) begin
    if (rom_en) rom_data <= 16'hA000 | {12'h000, rom_addr};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    txn       = 1'b0;
    last_srv  = 1'b1;
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
    v_edge[0] = -100;
    v_edge[1] = -100;
  endtask

  // advance the schedule by one rising edge, using the inputs seen at it
  task automatic model_edge();
    bit e0, e1, w;
    k++;
    if (!rst_n) return;
    if (txn && k == g_edge + 2) begin
      exp_rd[g_id] = 16'hA000 | {12'h000, g_addr};
      v_edge[g_id] = k;
    end
    if (!txn || k >= g_edge + 3) begin
      txn = 1'b0;
      e0 = req0 && (v_edge[0] != k - 1);
      e1 = req1 && (v_edge[1] != k - 1);
      if (e0 || e1) begin
        if (e0 && e1) w = ~last_srv;
        else          w = e1;
        txn      = 1'b1;
        g_edge   = k;
        g_id     = w;
        g_addr   = w ? addr1 : addr0;
        last_srv = w;
      end
    end
  endtask

  task automatic check_outputs();
    bit en_e, busy_e, v0_e, v1_e;
    en_e   = txn && (k == g_edge);
    busy_e = txn && (k == g_edge || k == g_edge + 1);
    v0_e   = txn && (k == g_edge + 2) && !g_id;
    v1_e   = txn && (k == g_edge + 2) && g_id;
    check_eq("rom_en", 32'(rom_en), 32'(en_e));
    if (en_e) check_eq("rom_addr", 32'(rom_addr), 32'(g_addr));
    check_eq("busy", 32'(busy), 32'(busy_e));
    check_eq("valid0", 32'(valid0), 32'(v0_e));
    check_eq("valid1", 32'(valid1), 32'(v1_e));
    check_eq("rdata0", 32'(rdata0), 32'(exp_rd[0]));
    check_eq("rdata1", 32'(rdata1), 32'(exp_rd[1]));
    check_eq("valid_excl", 32'(valid0 & valid1), 32'h0);
    if (valid0) begin obs_id.push_back(0); obs_data.push_back(rdata0); end
    if (valid1) begin obs_id.push_back(1); obs_data.push_back(rdata1); end
  endtask

  // requester behaviour after observing the current cycle
  task automatic drive(input bit rnd);
    if (req0 && valid0) begin
      if (!hold0) begin
        if (rnd && $urandom_range(0, 2) == 0) addr0 = 4'($urandom_range(0, 15));
        else req0 = 1'b0;
      end
    end else if (!req0 && rnd && $urandom_range(0, 2) == 0) begin
      req0  = 1'b1;
      addr0 = 4'($urandom_range(0, 15));
    end
    if (req1 && valid1) begin
      if (!hold1) begin
        if (rnd && $urandom_range(0, 2) == 0) addr1 = 4'($urandom_range(0, 15));
        else req1 = 1'b0;
      end
    end else if (!req1 && rnd && $urandom_range(0, 2) == 0) begin
      req1  = 1'b1;
      addr1 = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic step(input bit rnd);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    drive(rnd);
  endtask

  // asynchronous reset in mid low-phase; outputs must clear before any edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_obs();
    obs_id.delete();
    obs_data.delete();
  endtask

  initial begin
    k = 0; g_edge = -100; g_id = 1'b0; g_addr = 4'h0;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = 4'h0; addr1 = 4'h0;
    hold0 = 1'b0; hold1 = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // single read from requester 0
    req0 = 1'b1; addr0 = 4'h3;
    repeat (6) step(1'b0);
    check_eq("single_n", 32'(obs_id.size()), 32'd1);
    if (obs_id.size() >= 1) begin
      check_eq("single_id", 32'(obs_id[0]), 32'd0);
      check_eq("single_data", 32'(obs_data[0]), 32'h0000A003);
    end
    clear_obs();

    // tie right after reset: requester 0 first
    do_reset();
    req0 = 1'b1; addr0 = 4'h1; req1 = 1'b1; addr1 = 4'h7;
    repeat (9) step(1'b0);
    check_eq("tie_n", 32'(obs_id.size()), 32'd2);
    if (obs_id.size() >= 2) begin
      check_eq("tie_id0", 32'(obs_id[0]), 32'd0);
      check_eq("tie_data0", 32'(obs_data[0]), 32'h0000A001);
      check_eq("tie_id1", 32'(obs_id[1]), 32'd1);
      check_eq("tie_data1", 32'(obs_data[1]), 32'h0000A007);
    end
    clear_obs();

    // fairness: both held continuously for six transactions
    do_reset();
    hold0 = 1'b1; hold1 = 1'b1;
    req0 = 1'b1; addr0 = 4'h2; req1 = 1'b1; addr1 = 4'hC;
    repeat (18) step(1'b0);
    hold0 = 1'b0; hold1 = 1'b0;
    repeat (8) step(1'b0);
    check_eq("fair_n_ge6", 32'(obs_id.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_id.size()) check_eq("fair_id", 32'(obs_id[i]), 32'(i % 2));
    end
    clear_obs();

    // late request from requester 1 during ISSUE of a requester-0 read
    req0 = 1'b1; addr0 = 4'h5;
    step(1'b0);
    req1 = 1'b1; addr1 = 4'h9;
    repeat (8) step(1'b0);
    check_eq("late_n", 32'(obs_id.size()), 32'd2);
    if (obs_id.size() >= 2) begin
      check_eq("late_id0", 32'(obs_id[0]), 32'd0);
      check_eq("late_data0", 32'(obs_data[0]), 32'h0000A005);
      check_eq("late_id1", 32'(obs_id[1]), 32'd1);
      check_eq("late_data1", 32'(obs_data[1]), 32'h0000A009);
    end
    clear_obs();

    // reset during RESP discards the read
    req0 = 1'b1; addr0 = 4'hA;
    step(1'b0);
    step(1'b0);
    do_reset();
    repeat (5) step(1'b0);
    check_eq("rst_no_valid", 32'(obs_id.size()), 32'd0);
    req0 = 1'b1; addr0 = 4'hF;
    repeat (5) step(1'b0);
    check_eq("rst_next_n", 32'(obs_id.size()), 32'd1);
    if (obs_id.size() >= 1) check_eq("rst_next_data", 32'(obs_data[0]), 32'h0000A00F);
    clear_obs();

    // idle hold
    repeat (10) step(1'b0);
    check_eq("idle_no_valid", 32'(obs_id.size()), 32'd0);

    // randomized traffic, then drain
    repeat (400) step(1'b1);
    repeat (12) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
